// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter sharing one UART Tx path among byte requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BUSY_WAIT = 4
) (
    input  logic                       clk_50m,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         grant_ack,
    output logic [7:0]                 data_in,
    output logic                       wr_en,
    input  logic                       Tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] active_id,
    output logic                       busy,
    output logic                       err_timeout
);

    localparam int             c_ID_W      = $clog2(NUM_REQ);
    localparam logic [8:0]     c_BUSY_WAIT = 9'(BUSY_WAIT);
    localparam logic [c_ID_W-1:0] c_PTR_RST = c_ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_ID_W-1:0]    r_ptr;
    logic [7:0]           r_cnt;
    logic [NUM_REQ-1:0]   r_grant_ack;
    logic [7:0]           r_data_in;
    logic                 r_wr_en;
    logic [c_ID_W-1:0]    r_active_id;
    logic                 r_busy;
    logic                 r_err_timeout;

    state_t               w_state_nxt;
    logic [c_ID_W-1:0]    w_ptr_nxt;
    logic [7:0]           w_cnt_nxt;
    logic [NUM_REQ-1:0]   w_grant_ack_nxt;
    logic [7:0]           w_data_in_nxt;
    logic                 w_wr_en_nxt;
    logic [c_ID_W-1:0]    w_active_id_nxt;
    logic                 w_busy_nxt;
    logic                 w_err_timeout_nxt;

    logic                 w_found;
    logic [c_ID_W-1:0]    w_winner;
    int                   w_pos;
    logic [8:0]           w_cnt_inc;

    // Scan from the farthest position back to ptr+1 so the nearest
    // requester after the pointer is the last (and winning) assignment.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_pos    = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_pos = int'(r_ptr) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            if (req[w_pos[c_ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_pos[c_ID_W-1:0];
            end
        end
    end

    assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_cnt_nxt         = r_cnt;
        w_grant_ack_nxt   = '0;
        w_data_in_nxt     = r_data_in;
        w_wr_en_nxt       = 1'b0;
        w_active_id_nxt   = r_active_id;
        w_busy_nxt        = r_busy;
        w_err_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (w_found && !Tx_busy) begin
                    w_state_nxt     = S_ISSUE;
                    w_wr_en_nxt     = 1'b1;
                    w_grant_ack_nxt = NUM_REQ'(1) << w_winner;
                    w_data_in_nxt   = req_data[{w_winner, 3'b000} +: 8];
                    w_ptr_nxt       = w_winner;
                    w_active_id_nxt = w_winner;
                    w_busy_nxt      = 1'b1;
                end
            end
            S_ISSUE: begin
                w_cnt_nxt   = 8'd0;
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (Tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (w_cnt_inc == c_BUSY_WAIT) begin
                    // Transmitter never acknowledged: drop the byte.
                    w_err_timeout_nxt = 1'b1;
                    w_busy_nxt        = 1'b0;
                    w_cnt_nxt         = 8'd0;
                    w_state_nxt       = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc[7:0];
                end
            end
            S_WAIT_DONE: begin
                if (!Tx_busy) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= c_PTR_RST;
            r_cnt         <= 8'd0;
            r_grant_ack   <= '0;
            r_data_in     <= 8'd0;
            r_wr_en       <= 1'b0;
            r_active_id   <= '0;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_grant_ack   <= w_grant_ack_nxt;
            r_data_in     <= w_data_in_nxt;
            r_wr_en       <= w_wr_en_nxt;
            r_active_id   <= w_active_id_nxt;
            r_busy        <= w_busy_nxt;
            r_err_timeout <= w_err_timeout_nxt;
        end
    end

    assign grant_ack   = r_grant_ack;
    assign data_in     = r_data_in;
    assign wr_en       = r_wr_en;
    assign active_id   = r_active_id;
    assign busy        = r_busy;
    assign err_timeout = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed vector table, corner sequences and random traffic for
//            uart_tx_arbiter against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int BW = 4;

    logic        clk_50m = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant_ack;
    logic [7:0]  data_in;
    logic        wr_en;
    logic        Tx_busy;
    logic [1:0]  active_id;
    logic        busy;
    logic        err_timeout;

    always #10 clk_50m = ~clk_50m;

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_WAIT(BW)) dut (
        .clk_50m     (clk_50m),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .grant_ack   (grant_ack),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .Tx_busy     (Tx_busy),
        .active_id   (active_id),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        case (i)
            0: req_data[7:0]   = b;
            1: req_data[15:8]  = b;
            2: req_data[23:16] = b;
            default: req_data[31:24] = b;
        endcase
    endtask

    task automatic chk_all(input string tag, input logic w, input logic [3:0] a,
                           input logic [7:0] d, input logic [1:0] id,
                           input logic b, input logic to);
        chk({tag, ".wr_en"},       32'(wr_en),       32'(w));
        chk({tag, ".grant_ack"},   32'(grant_ack),   32'(a));
        chk({tag, ".data_in"},     32'(data_in),     32'(d));
        chk({tag, ".active_id"},   32'(active_id),   32'(id));
        chk({tag, ".busy"},        32'(busy),        32'(b));
        chk({tag, ".err_timeout"}, 32'(err_timeout), 32'(to));
    endtask

    // Reference model: tracks whether the shared transmitter slot is free,
    // how many cycles have passed since the last issue, and whether the
    // transmitter has acknowledged the byte yet.
    bit         m_free;
    int         m_ptr;
    int         m_since;
    bit         m_saw;
    logic       e_wr, e_busy, e_to;
    logic [3:0] e_ack;
    logic [7:0] e_data;
    logic [1:0] e_id;

    task automatic model_step(input logic r, input logic [3:0] rq,
                              input logic [31:0] rd, input logic txb);
        int          w;
        int          c;
        logic [31:0] sh;
        e_wr  = 1'b0;
        e_ack = 4'b0;
        e_to  = 1'b0;
        if (r) begin
            m_free = 1'b1;
            m_ptr  = N - 1;
            e_data = 8'd0;
            e_id   = 2'd0;
            e_busy = 1'b0;
        end else if (m_free) begin
            if (rq != 4'b0 && !txb) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (m_ptr + k) % N;
                    if (w < 0 && ((rq >> c) & 4'b1) != 4'b0) w = c;
                end
                sh      = rd >> (8 * w);
                e_wr    = 1'b1;
                e_ack   = 4'(1 << w);
                e_data  = sh[7:0];
                e_id    = 2'(w);
                e_busy  = 1'b1;
                m_ptr   = w;
                m_free  = 1'b0;
                m_since = 0;
                m_saw   = 1'b0;
            end
        end else if (m_since == 0) begin
            m_since = 1;
        end else if (!m_saw) begin
            if (txb) begin
                m_saw = 1'b1;
            end else if (m_since == BW) begin
                e_to   = 1'b1;
                e_busy = 1'b0;
                m_free = 1'b1;
            end else begin
                m_since++;
            end
        end else if (!txb) begin
            m_free = 1'b1;
            e_busy = 1'b0;
        end
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] data;
        logic [1:0]  exp_id;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs[8];
    int   tx_delay;
    int   tx_rem;

    initial begin
        rst      = 1'b1;
        req      = 4'b0;
        req_data = 32'b0;
        Tx_busy  = 1'b0;

        // Grant order starting from the reset pointer (N-1).
        vecs[0] = '{4'b1111, 32'h13121110, 2'd0, 8'h10};
        vecs[1] = '{4'b0010, 32'h23222120, 2'd1, 8'h21};
        vecs[2] = '{4'b1111, 32'h33323130, 2'd2, 8'h32};
        vecs[3] = '{4'b0011, 32'h43424140, 2'd0, 8'h40};
        vecs[4] = '{4'b1001, 32'h53525150, 2'd3, 8'h53};
        vecs[5] = '{4'b1000, 32'h63626160, 2'd3, 8'h63};
        vecs[6] = '{4'b0101, 32'h73727170, 2'd0, 8'h70};
        vecs[7] = '{4'b1110, 32'h83828180, 2'd1, 8'h81};

        tick();
        tick();
        chk_all("reset", 1'b0, 4'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        for (int r = 0; r < 8; r++) begin
            req      = vecs[r].mask;
            req_data = vecs[r].data;
            tick();
            chk_all($sformatf("vec%0d.issue", r), 1'b1, 4'(1 << vecs[r].exp_id),
                    vecs[r].exp_byte, vecs[r].exp_id, 1'b1, 1'b0);
            req = 4'b0;
            tick();
            chk($sformatf("vec%0d.wait_wr", r), 32'(wr_en), 32'd0);
            Tx_busy = 1'b1;
            tick();
            tick();
            Tx_busy = 1'b0;
            tick();
            chk($sformatf("vec%0d.idle_busy", r), 32'(busy), 32'd0);
            chk($sformatf("vec%0d.held_data", r), 32'(data_in), 32'(vecs[r].exp_byte));
        end

        // Timeout: transmitter never rises; requester 3 keeps requesting.
        req = 4'b1000;
        set_byte(3, 8'hC3);
        tick();
        chk_all("to.issue", 1'b1, 4'b1000, 8'hC3, 2'd3, 1'b1, 1'b0);
        set_byte(3, 8'h5A);
        for (int j = 1; j <= BW; j++) begin
            tick();
            chk($sformatf("to.wait%0d.err", j), 32'(err_timeout), 32'd0);
            chk($sformatf("to.wait%0d.busy", j), 32'(busy), 32'd1);
        end
        tick();
        chk("to.pulse.err", 32'(err_timeout), 32'd1);
        chk("to.pulse.busy", 32'(busy), 32'd0);
        chk("to.pulse.wr", 32'(wr_en), 32'd0);
        tick();
        chk_all("to.regrant", 1'b1, 4'b1000, 8'h5A, 2'd3, 1'b1, 1'b0);
        req = 4'b0;
        tick();
        Tx_busy = 1'b1;
        tick();
        Tx_busy = 1'b0;
        tick();
        chk("to.done.busy", 32'(busy), 32'd0);

        // Reset while the frame is in flight; no issue until Tx_busy falls.
        req = 4'b0100;
        set_byte(2, 8'h77);
        tick();
        chk("rmf.issue.ack", 32'(grant_ack), 32'b0100);
        req = 4'b0001;
        set_byte(0, 8'h99);
        Tx_busy = 1'b1;
        tick();
        tick();
        chk("rmf.wait_done.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk_all("rmf.reset", 1'b0, 4'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk($sformatf("rmf.hold%0d.wr", j), 32'(wr_en), 32'd0);
        end
        Tx_busy = 1'b0;
        tick();
        chk_all("rmf.grant", 1'b1, 4'b0001, 8'h99, 2'd0, 1'b1, 1'b0);

        // Requester 1 pulses only during WAIT_DONE: must never be granted.
        req = 4'b0;
        tick();
        Tx_busy = 1'b1;
        tick();
        req = 4'b0010;
        tick();
        req = 4'b0;
        tick();
        Tx_busy = 1'b0;
        tick();
        chk("wd.idle.busy", 32'(busy), 32'd0);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk($sformatf("wd.idle%0d.wr", j), 32'(wr_en), 32'd0);
            chk($sformatf("wd.idle%0d.ack", j), 32'(grant_ack), 32'd0);
        end

        // Random traffic against the reference model.
        rst      = 1'b1;
        req      = 4'b0;
        Tx_busy  = 1'b0;
        tx_delay = 0;
        tx_rem   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            model_step(rst, req, req_data, Tx_busy);
            chk_all("rand", e_wr, e_ack, e_data, e_id, e_busy, e_to);
            rst = 1'b0;
            if (wr_en) begin
                tx_delay = $urandom_range(1, BW + 1);
                tx_rem   = 0;
            end else if (tx_delay > 0) begin
                tx_delay--;
                if (tx_delay == 0) begin
                    Tx_busy = 1'b1;
                    tx_rem  = $urandom_range(1, 6);
                end
            end else if (tx_rem > 0) begin
                tx_rem--;
                if (tx_rem == 0) Tx_busy = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (grant_ack[i[1:0]]) begin
                    if ($urandom_range(0, 1) == 0) req[i[1:0]] = 1'b0;
                    else set_byte(i, 8'($urandom));
                end else if (req[i[1:0]]) begin
                    if ($urandom_range(0, 15) == 0) req[i[1:0]] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i[1:0]] = 1'b1;
                    set_byte(i, 8'($urandom));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single UART transmitter (the `uart_top` Tx path: `data_in`, `wr_en`, `Tx_busy`) between `NUM_REQ` byte requesters. It accepts one byte at a time from the next requesting client and issues a one-cycle `wr_en` strobe with the byte on `data_in`. It then tracks `Tx_busy` through the frame and only issues the next byte once the transmitter has returned to idle. It sits between the client logic and `uart_top`, so clients never drive `wr_en` directly.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `BUSY_WAIT`, default 4: maximum cycles in WAIT_BUSY for `Tx_busy` to rise before a timeout is declared, 1..255.

Ports (clock and reset first):
- `clk_50m`  in  1: system clock. Every register updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  `NUM_REQ`: per-requester byte request. A requester holds `req` high with its data stable until it sees its ack.
- `req_data`  in  `8*NUM_REQ`: requester i byte on bits [8i+7:8i].
- `grant_ack`  out  `NUM_REQ`: one-hot, one-cycle pulse marking the byte of requester i as taken.
- `data_in`  out  8: byte to the transmitter. Held stable after issue until the next issue.
- `wr_en`  out  1: one-cycle transmit strobe to the transmitter.
- `Tx_busy`  in  1: transmitter busy, driven by `uart_top`.
- `active_id`  out  `$clog2(NUM_REQ)`: index of the last granted requester.
- `busy`  out  1: high whenever the arbiter is not in IDLE.
- `err_timeout`  out  1: one-cycle pulse when `Tx_busy` fails to rise within `BUSY_WAIT` cycles.

## Operation
State machine with four states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE. All outputs are registered.
- **IDLE.** If any `req` bit is set and `Tx_busy`==0:
  - select the winner by round-robin search starting at `ptr+1` mod `NUM_REQ`;
  - go to ISSUE.
  - If `Tx_busy`==1, stay in IDLE regardless of `req`.
- **ISSUE (1 cycle).**
  - `wr_en`=1.
  - `data_in` = winner's byte.
  - `grant_ack[winner]`=1.
  - `ptr` and `active_id` are set to the winner.
  - Clear the wait counter, then go to WAIT_BUSY.
- **WAIT_BUSY.**
  - On `Tx_busy`==1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches `BUSY_WAIT`, pulse `err_timeout` for one cycle and return to IDLE. The byte is dropped and not retried.
- **WAIT_DONE.** When `Tx_busy`==0, go to IDLE.
- **Round-robin pointer.** Reset value of `ptr` is `NUM_REQ-1`, so requester 0 wins first after reset. Only a requester whose `req` is high in the IDLE cycle is eligible.
- **Request handshake.**
  - The byte is captured in the same edge that raises `grant_ack`.
  - A requester may keep `req` high to queue another byte. Its next grant follows the round-robin order.
  - Dropping `req` before grant withdraws the request with no side effect.
- **Reset.** `rst` in any state forces IDLE.
  - `ptr`=`NUM_REQ-1`.
  - `data_in`=0, `wr_en`=0, `grant_ack`=0, `active_id`=0, `busy`=0, `err_timeout`=0, counter=0.
  - A frame already in flight in the transmitter is not aborted. The IDLE guard on `Tx_busy` prevents a new issue until that frame ends.

## Timing
- **Request to strobe.** `req` sampled high in IDLE at edge t gives `wr_en`/`grant_ack` high during cycle t+1, i.e. 1-cycle latency.
- **Strobe shape.** `wr_en` is exactly one cycle and is never asserted while `Tx_busy`==1 was seen in the preceding IDLE cycle.
- **Strobe spacing.** Minimum spacing between strobes is ISSUE(1) + WAIT_BUSY(≥1) + WAIT_DONE(frame length) + IDLE(1) cycles.
- **Timeout position.** `err_timeout` is asserted in the cycle after the `BUSY_WAIT`-th WAIT_BUSY cycle with `Tx_busy` low. `busy` deasserts in that same cycle.
- **`busy` window.** `busy` is high from ISSUE through the last WAIT_DONE cycle.
- **Simultaneous events.** Several `req` bits rising in the same cycle are served one byte each, in round-robin order starting after `ptr`.

## Test plan
1. **Single byte.** `req[1]`=1 with byte 0xAB, looped back through `uart_top` at 50 MHz.
   - Expect one `wr_en` pulse and `grant_ack`=4'b0010.
   - Receiver reports 0xAB; `busy` falls after `Tx_busy` falls.
2. **Two requesters.** `req[0]` and `req[2]` rise in the same cycle with 0x11 and 0x33.
   - Expect transmit order 0x11 then 0x33, with `active_id` 0 then 2.
3. **Fairness.** All four `req` held high, each byte incrementing per grant.
   - Expect grant order 0,1,2,3,0,1 and no requester granted twice in a row.
   - Every byte received equal to the byte sent.
4. **Timeout.** `Tx_busy` tied to 0, `req[3]`=1.
   - Expect `err_timeout` pulse exactly `BUSY_WAIT`+1 cycles after the `wr_en` cycle.
   - Then re-grant of requester 3 once it is re-eligible.
5. **Reset mid-frame.** Assert `rst` one cycle during WAIT_DONE with `Tx_busy`=1 and `req[0]`=1.
   - Expect all outputs 0 in the next cycle.
   - Expect no `wr_en` until `Tx_busy` falls, then a grant to requester 0.
6. **Withdrawn request.** Pulse `req[1]` high only during WAIT_DONE of another transfer.
   - Expect no grant to requester 1 and no extra `wr_en`.
